// File: rtl/tile_render_pkg.sv
// Shared defaults and FSM state encoding for the tile renderer.
package tile_render_pkg;

   localparam int          DEF_TYPE_W     = 5;
   localparam int          DEF_COLOR_W    = 12;
   localparam logic [11:0] DEF_BG_COLOR   = 12'h000;
   localparam logic [11:0] DEF_GRID_COLOR = 12'hFFF;

   // Map storage controller: normal operation or sweeping zeros through the map.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } map_state_t;

endpackage

// File: rtl/tile_render_pipe_map.sv
// tile_map_ram: tile-type map storage with a single write port, a registered
// read port and a linear clear sequencer (also run out of reset).
module tile_map_ram
   import tile_render_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int TYPE_W = DEF_TYPE_W,
   parameter int AW     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [TYPE_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [TYPE_W-1:0] rdata_o,
   output logic              busy_o
);

   logic [TYPE_W-1:0] mem [DEPTH];

   map_state_t        state, state_nxt;
   logic [AW-1:0]     cnt, cnt_nxt;
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [TYPE_W-1:0] mem_wdata;

   // State and clear counter; reset lands in CLEAR so the map starts zeroed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and write-port steering: the clear sweep owns the port while busy.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mem_we    = 1'b0;
      mem_waddr = waddr_i;
      mem_wdata = wdata_i;
      busy_o    = 1'b0;
      case (state)
         ST_IDLE: begin
            mem_we = we_i;
            if (clear_i) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            busy_o    = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = '0;
            if (cnt == AW'(DEPTH - 1)) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Storage array; no reset, contents are defined by the clear sweep.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Registered read: returns the pre-write value on a same-cycle collision,
   // and type 0 for the whole clear so half-cleared contents never leak out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  rdata_o <= '0;
      else if (state == ST_CLEAR)  rdata_o <= '0;
      else                         rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/tile_render_pipe.sv
// tile_render_pipe: 3-stage pixel pipe. Stage 1 looks up the tile type and
// presents the texture ROM address, stage 2 waits on ROM data, stage 3
// registers the final colour. Optional grid overlay: TILE_RENDER_GRID_EN.
module tile_render_pipe
   import tile_render_pkg::*;
#(
   parameter int TILE_LOG2 = 5,
   parameter int MAP_W     = 16,
   parameter int MAP_H     = 16,
   parameter int TYPE_W    = DEF_TYPE_W,
   parameter int COLOR_W   = DEF_COLOR_W,
   parameter int X_W       = 10,
   parameter int Y_W       = 10,
   parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(DEF_BG_COLOR)
`ifdef TILE_RENDER_GRID_EN
   ,
   parameter logic [COLOR_W-1:0] GRID_COLOR = COLOR_W'(DEF_GRID_COLOR)
`endif
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pix_valid_i,
   input  logic [X_W-1:0]             pix_x_i,
   input  logic [Y_W-1:0]             pix_y_i,
   input  logic                       map_we_i,
   input  logic [$clog2(MAP_W)-1:0]   map_wx_i,
   input  logic [$clog2(MAP_H)-1:0]   map_wy_i,
   input  logic [TYPE_W-1:0]          map_wdata_i,
   input  logic                       map_clear_i,
   output logic                       busy_o,
   output logic [TYPE_W-1:0]          tex_type_o,
   output logic [TILE_LOG2-1:0]       tex_u_o,
   output logic [TILE_LOG2-1:0]       tex_v_o,
   input  logic [COLOR_W-1:0]         tex_data_i,
   output logic                       pix_valid_o,
   output logic [COLOR_W-1:0]         pix_data_o
);

   localparam int          DEPTH   = MAP_W * MAP_H;
   localparam int          AW      = $clog2(DEPTH);
   localparam int          CX_W    = X_W - TILE_LOG2;
   localparam int          CY_W    = Y_W - TILE_LOG2;
   localparam int          STAGES  = 3;
   localparam logic [31:0] MAP_W_U = MAP_W;
   localparam logic [31:0] MAP_H_U = MAP_H;

   typedef struct packed {
      logic                 oob;
      logic [TILE_LOG2-1:0] u;
      logic [TILE_LOG2-1:0] v;
   } px_meta_t;

   logic [CX_W-1:0]      cell_x;
   logic [CY_W-1:0]      cell_y;
   logic                 oob0;
   logic [AW-1:0]        raddr;
   logic [AW-1:0]        waddr;
   logic                 wr_ok;
   logic [TYPE_W-1:0]    map_type;
   px_meta_t             s1;
   logic [STAGES:1]      vld_pipe;
   logic                 oob_s2;
   logic [COLOR_W-1:0]   pix_nxt;

   // Cell / offset split and linear map addresses (32-bit math avoids
   // constant-range compares when a coordinate field cannot exceed the map).
   assign cell_x = pix_x_i[X_W-1:TILE_LOG2];
   assign cell_y = pix_y_i[Y_W-1:TILE_LOG2];
   assign oob0   = (32'(cell_x) >= MAP_W_U) || (32'(cell_y) >= MAP_H_U);
   assign raddr  = oob0 ? '0 : AW'(32'(cell_y) * MAP_W_U + 32'(cell_x));
   assign wr_ok  = map_we_i && (32'(map_wx_i) < MAP_W_U) && (32'(map_wy_i) < MAP_H_U);
   assign waddr  = AW'(32'(map_wy_i) * MAP_W_U + 32'(map_wx_i));

   tile_map_ram #(
      .DEPTH  (DEPTH),
      .TYPE_W (TYPE_W),
      .AW     (AW)
   ) u_map (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (map_clear_i),
      .we_i    (wr_ok),
      .waddr_i (waddr),
      .wdata_i (map_wdata_i),
      .raddr_i (raddr),
      .rdata_o (map_type),
      .busy_o  (busy_o)
   );

   // Valid shift register plus stage-1 pixel metadata alongside the map read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1       <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid_i};
         s1       <= '{oob: oob0, u: pix_x_i[TILE_LOG2-1:0], v: pix_y_i[TILE_LOG2-1:0]};
      end
   end

   // Out-of-map cells fetch texture type 0; the colour is replaced later anyway.
   assign tex_type_o = s1.oob ? '0 : map_type;
   assign tex_u_o    = s1.u;
   assign tex_v_o    = s1.v;

   // Stage 2: carry the colour-override flags while the ROM answers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) oob_s2 <= 1'b0;
      else        oob_s2 <= s1.oob;
   end

`ifdef TILE_RENDER_GRID_EN
   logic grid_s2;

   // Stage 2: grid lines on the first row/column of every tile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) grid_s2 <= 1'b0;
      else        grid_s2 <= (s1.u == '0) || (s1.v == '0);
   end
`endif

   // Colour select: background beats grid beats texture.
   always_comb begin
      pix_nxt = tex_data_i;
`ifdef TILE_RENDER_GRID_EN
      if (grid_s2) pix_nxt = GRID_COLOR;
`endif
      if (oob_s2)  pix_nxt = BG_COLOR;
   end

   // Stage 3 output register; holds its value through bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            pix_data_o <= BG_COLOR;
      else if (vld_pipe[2])  pix_data_o <= pix_nxt;
   end

   assign pix_valid_o = vld_pipe[STAGES];

endmodule

// File: tb/tb_tile_render_pipe.sv
// Testbench for tile_render_pipe: table-driven vectors plus scoreboard queues.
module tb_tile_render_pipe;
   import tile_render_pkg::*;

   localparam int          TL    = 5;
   localparam int          MW    = 16;
   localparam int          MH    = 16;
   localparam int          NCELL = MW * MH;
   localparam logic [11:0] BG    = 12'h000;
   localparam logic [11:0] GRID  = 12'hFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_valid_i = 1'b0;
   logic [9:0]  pix_x_i = '0;
   logic [9:0]  pix_y_i = '0;
   logic        map_we_i = 1'b0;
   logic [3:0]  map_wx_i = '0;
   logic [3:0]  map_wy_i = '0;
   logic [4:0]  map_wdata_i = '0;
   logic        map_clear_i = 1'b0;
   logic        busy_o;
   logic [4:0]  tex_type_o;
   logic [4:0]  tex_u_o;
   logic [4:0]  tex_v_o;
   logic [11:0] tex_data_i = '0;
   logic        pix_valid_o;
   logic [11:0] pix_data_o;

   always #5 clk = ~clk;

   tile_render_pipe #(
      .TILE_LOG2(TL), .MAP_W(MW), .MAP_H(MH), .TYPE_W(5), .COLOR_W(12),
      .X_W(10), .Y_W(10), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pix_valid_i(pix_valid_i), .pix_x_i(pix_x_i), .pix_y_i(pix_y_i),
      .map_we_i(map_we_i), .map_wx_i(map_wx_i), .map_wy_i(map_wy_i),
      .map_wdata_i(map_wdata_i), .map_clear_i(map_clear_i), .busy_o(busy_o),
      .tex_type_o(tex_type_o), .tex_u_o(tex_u_o), .tex_v_o(tex_v_o),
      .tex_data_i(tex_data_i), .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o)
   );

   // Texture ROM model, one registered cycle of latency.
   function automatic logic [11:0] rom(input logic [4:0] t, input logic [4:0] u, input logic [4:0] v);
      if (t == 5'd7 && u == 5'd4 && v == 5'd6) return 12'hABC;
      return {t[3:0], 8'h00} ^ {2'b00, u, v} ^ 12'h5A3;
   endfunction

   always @(posedge clk) tex_data_i <= rom(tex_type_o, tex_u_o, tex_v_o);

   typedef struct {
      int          cyc;
      logic [4:0]  typ;
      logic [4:0]  u;
      logic [4:0]  v;
      logic [11:0] pix;
   } exp_t;

   typedef struct {
      bit pv; int x; int y; bit we; int wx; int wy; int wd;
      int e_type; int e_u; int e_v; bit e_oob;
   } vec_t;

   exp_t        texq[$];
   exp_t        pixq[$];
   logic [4:0]  model [NCELL];
   int          busy_left = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   logic [11:0] last_pix = BG;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic zero_model();
      for (int i = 0; i < NCELL; i++) model[i] = '0;
   endtask

   // One cycle: check busy, drive inputs, push expectations, advance the map model.
   task automatic drive(input bit pv, input int x, input int y,
                        input bit we, input int wx, input int wy, input int wd,
                        input bit clr, input bit has_exp,
                        input int e_type, input int e_u, input int e_v, input bit e_oob);
      exp_t r;
      int   cx, cy;
      bit   oob;
      @(posedge clk);
      cyc++;
      #1;
      chk("busy", 32'(busy_o), 32'(busy_left > 0));
      pix_valid_i = pv;
      pix_x_i     = 10'(x);
      pix_y_i     = 10'(y);
      map_we_i    = we;
      map_wx_i    = 4'(wx);
      map_wy_i    = 4'(wy);
      map_wdata_i = 5'(wd);
      map_clear_i = clr;
      cx  = x >> TL;
      cy  = y >> TL;
      oob = (cx >= MW) || (cy >= MH);
      if (has_exp) begin
         r.typ = 5'(e_type); r.u = 5'(e_u); r.v = 5'(e_v); oob = e_oob;
      end else begin
         r.u = 5'(x); r.v = 5'(y);
         if (oob || busy_left > 0) r.typ = '0;
         else                      r.typ = model[cy * MW + cx];
      end
      r.cyc = cyc;
      r.pix = oob ? BG : rom(r.typ, r.u, r.v);
`ifdef TILE_RENDER_GRID_EN
      if (!oob && (r.u == 0 || r.v == 0)) r.pix = GRID;
`endif
      if (pv) begin
         texq.push_back(r);
         pixq.push_back(r);
      end
      // Map model update for the coming edge (same-cycle read saw old data).
      if (busy_left > 0) busy_left--;
      else if (clr) begin busy_left = NCELL; zero_model(); end
      else if (we && wx < MW && wy < MH) model[wy * MW + wx] = 5'(wd);
   endtask

   task automatic pix(input int x, input int y);
      drive(1'b1, x, y, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   // Output monitor: stage-1 texture address and stage-3 pixel against the scoreboard.
   always @(negedge clk) begin
      exp_t r;
      if (mon_en) begin
         if (texq.size() > 0 && texq[0].cyc + 1 == cyc) begin
            r = texq.pop_front();
            chk("tex_type", 32'(tex_type_o), 32'(r.typ));
            chk("tex_u", 32'(tex_u_o), 32'(r.u));
            chk("tex_v", 32'(tex_v_o), 32'(r.v));
         end
         if (pix_valid_o) begin
            if (pixq.size() == 0) chk("pix_spurious", 32'(pix_valid_o), 32'd0);
            else begin
               r = pixq.pop_front();
               chk("pix_latency", 32'(cyc), 32'(r.cyc + 3));
               chk("pix_data", 32'(pix_data_o), 32'(r.pix));
               last_pix = r.pix;
            end
         end else begin
            if (pixq.size() > 0 && pixq[0].cyc + 3 <= cyc) begin
               chk("pix_missing", 32'(pix_valid_o), 32'd1);
               void'(pixq.pop_front());
            end
            chk("pix_hold", 32'(pix_data_o), 32'(last_pix));
         end
      end
   end

   task automatic check_reset_state();
      chk("rst_tex_type", 32'(tex_type_o), 32'd0);
      chk("rst_tex_u", 32'(tex_u_o), 32'd0);
      chk("rst_tex_v", 32'(tex_v_o), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid_o), 32'd0);
      chk("rst_pix_data", 32'(pix_data_o), 32'(BG));
      chk("rst_busy", 32'(busy_o), 32'd1);
   endtask

   // The cycle in which reset is released is the first clear cycle, so the
   // model counts the remaining NCELL-1 busy cycles from the next edge on.
   task automatic release_reset();
      rst_n     = 1'b1;
      busy_left = NCELL - 1;
      zero_model();
      last_pix  = BG;
      mon_en    = 1'b1;
   endtask

   vec_t vt[15];

   initial begin
      // {pv, x, y, we, wx, wy, wd, type, u, v, oob}
      vt[0]  = '{0,    0,    0, 1,  3,  2,  7,  0,  0,  0, 0};
      vt[1]  = '{1,  100,   70, 0,  0,  0,  0,  7,  4,  6, 0};
      vt[2]  = '{1,  600,   10, 0,  0,  0,  0,  0, 24, 10, 1};
      vt[3]  = '{1,   40,   40, 1,  1,  1,  5,  0,  8,  8, 0};
      vt[4]  = '{1,   41,   40, 0,  0,  0,  0,  5,  9,  8, 0};
      vt[5]  = '{1,  511,  511, 1, 15, 15, 31,  0, 31, 31, 0};
      vt[6]  = '{1,  480,  480, 0,  0,  0,  0, 31,  0,  0, 0};
      vt[7]  = '{1,  512,    0, 0,  0,  0,  0,  0,  0,  0, 1};
      vt[8]  = '{1,    0,  512, 0,  0,  0,  0,  0,  0,  0, 1};
      vt[9]  = '{1, 1023, 1023, 0,  0,  0,  0,  0, 31, 31, 1};
      vt[10] = '{1,   64,   77, 0,  0,  0,  0,  0,  0, 13, 0};
      vt[11] = '{1,   65,   77, 0,  0,  0,  0,  0,  1, 13, 0};
      vt[12] = '{0,    0,    0, 0,  0,  0,  0,  0,  0,  0, 0};
      vt[13] = '{1,  127,   95, 0,  0,  0,  0,  7, 31, 31, 0};
      vt[14] = '{1,  496,    0, 0,  0,  0,  0,  0, 16,  0, 0};

      zero_model();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state();
      release_reset();
      chk("busy_at_release", 32'(busy_o), 32'd1);

      // Post-reset clear: continuous pixels read type 0, writes are ignored.
      for (int i = 0; i < 258; i++)
         drive(1'b1, (i * 37) % 1024, (i * 23) % 640, (i % 50) == 7, 3, 2, 9,
               1'b0, 1'b0, 0, 0, 0, 1'b0);
      idle(2);

      // Directed vectors with hand-derived expectations.
      for (int i = 0; i < 15; i++)
         drive(vt[i].pv, vt[i].x, vt[i].y, vt[i].we, vt[i].wx, vt[i].wy, vt[i].wd,
               1'b0, 1'b1, vt[i].e_type, vt[i].e_u, vt[i].e_v, vt[i].e_oob);
      idle(4);

      // Mid-frame clear with an unbroken pixel stream, writes and a repeat
      // clear request while busy.
      drive(1'b0, 0, 0, 1'b1, 5, 5, 3, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      drive(1'b0, 0, 0, 1'b1, 6, 6, 4, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 285; i++)
         drive(1'b1, (i[0] ? 192 : 160) + (i % 32), (i[0] ? 192 : 160) + (i % 7),
               (i % 16) == 3, 5, 5, 9 + (i % 5), (i == 10) || (i == 100),
               1'b0, 0, 0, 0, 1'b0);
      idle(4);

      // Reset with pixels in flight: they are dropped and the clear restarts.
      drive(1'b0, 0, 0, 1'b1, 3, 2, 7, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      pix(100, 70);
      pix(101, 71);
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      pix_valid_i = 1'b0;
      map_we_i = 1'b0;
      rst_n = 1'b0;
      texq.delete();
      pixq.delete();
      #1;
      check_reset_state();
      @(posedge clk);
      #1;
      chk("rst_pix_valid_held", 32'(pix_valid_o), 32'd0);
      release_reset();
      for (int i = 0; i < 260; i++) pix(96 + (i % 64), 64 + (i % 32));
      pix(100, 70);
      idle(5);
      chk("scoreboard_drained", 32'(texq.size() + pixq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
